// File: rtl/data_mem_controller.sv
`default_nettype none
// data_mem_controller: round-robin arbitration of LSU request lanes onto a few
// memory channels, each channel running a claim/wait/relay FSM.
module data_mem_controller #(
   parameter int NUM_CONSUMERS = 5,
   parameter int NUM_CHANNELS  = 2,
   parameter int ADDR_BITS     = 8,
   parameter int DATA_BITS     = 16
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [NUM_CONSUMERS-1:0]           consumer_valid,
   input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_addr,
   input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_data,
   input  logic [NUM_CONSUMERS-1:0]           consumer_we,
   output logic [NUM_CONSUMERS-1:0]           consumer_resp_ready,
   output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_resp_data,
   output logic [NUM_CHANNELS-1:0]            mem_read_valid,
   output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_addr,
   input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
   input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
   output logic [NUM_CHANNELS-1:0]            mem_write_valid,
   output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_addr,
   output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
   input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);

   localparam int LANE_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

   localparam logic [1:0] S_IDLE       = 2'd0;
   localparam logic [1:0] S_READ_WAIT  = 2'd1;
   localparam logic [1:0] S_WRITE_WAIT = 2'd2;
   localparam logic [1:0] S_RELAY      = 2'd3;

   logic [1:0]               state  [NUM_CHANNELS];
   logic [LANE_W-1:0]        lane   [NUM_CHANNELS];
   logic [ADDR_BITS-1:0]     addr_q [NUM_CHANNELS];
   logic [DATA_BITS-1:0]     data_q [NUM_CHANNELS];
   logic [NUM_CONSUMERS-1:0] served;
   logic [LANE_W-1:0]        rr;

   logic [NUM_CHANNELS-1:0]  claim_en;
   logic [LANE_W-1:0]        claim_lane [NUM_CHANNELS];
   logic [NUM_CONSUMERS-1:0] claimed;
   logic [NUM_CONSUMERS-1:0] released;
   logic [LANE_W-1:0]        rr_next;
   logic [LANE_W:0]          scan;

   // Channels claim in index order; a lane taken by a lower channel this cycle is skipped.
   always_comb begin
      claim_en = '0;
      claimed  = '0;
      released = '0;
      rr_next  = rr;
      scan     = '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         claim_lane[c] = '0;
         if (state[c] == S_IDLE) begin
            for (int k = 0; k < NUM_CONSUMERS; k++) begin
               scan = {1'b0, rr} + (LANE_W+1)'(k);
               if (scan >= (LANE_W+1)'(NUM_CONSUMERS))
                  scan = scan - (LANE_W+1)'(NUM_CONSUMERS);
               if (!claim_en[c] && consumer_valid[scan[LANE_W-1:0]] &&
                   !served[scan[LANE_W-1:0]] && !claimed[scan[LANE_W-1:0]]) begin
                  claim_en[c]                 = 1'b1;
                  claim_lane[c]               = scan[LANE_W-1:0];
                  claimed[scan[LANE_W-1:0]]   = 1'b1;
                  rr_next = (scan[LANE_W-1:0] == LANE_W'(NUM_CONSUMERS-1)) ?
                            '0 : scan[LANE_W-1:0] + LANE_W'(1);
               end
            end
         end else if (state[c] == S_RELAY && !consumer_valid[lane[c]]) begin
            released[lane[c]] = 1'b1;
         end
      end
   end

   always_comb begin
      mem_read_valid  = '0;
      mem_write_valid = '0;
      mem_read_addr   = '0;
      mem_write_addr  = '0;
      mem_write_data  = '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         if (state[c] == S_READ_WAIT) begin
            mem_read_valid[c]                      = 1'b1;
            mem_read_addr[c*ADDR_BITS +: ADDR_BITS] = addr_q[c];
         end
         if (state[c] == S_WRITE_WAIT) begin
            mem_write_valid[c]                      = 1'b1;
            mem_write_addr[c*ADDR_BITS +: ADDR_BITS] = addr_q[c];
            mem_write_data[c*DATA_BITS +: DATA_BITS] = data_q[c];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         consumer_resp_ready <= '0;
         consumer_resp_data  <= '0;
         served              <= '0;
         rr                  <= '0;
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            state[c]  <= S_IDLE;
            lane[c]   <= '0;
            addr_q[c] <= '0;
            data_q[c] <= '0;
         end
      end else begin
         consumer_resp_ready <= '0;
         served              <= (served | claimed) & ~released;
         rr                  <= rr_next;
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            case (state[c])
               S_IDLE: begin
                  if (claim_en[c]) begin
                     lane[c]   <= claim_lane[c];
                     addr_q[c] <= consumer_addr[claim_lane[c]*ADDR_BITS +: ADDR_BITS];
                     data_q[c] <= consumer_data[claim_lane[c]*DATA_BITS +: DATA_BITS];
                     state[c]  <= consumer_we[claim_lane[c]] ? S_WRITE_WAIT : S_READ_WAIT;
                  end
               end
               S_READ_WAIT: begin
                  if (mem_read_ready[c]) begin
                     consumer_resp_ready[lane[c]] <= 1'b1;
                     consumer_resp_data[lane[c]*DATA_BITS +: DATA_BITS] <=
                        mem_read_data[c*DATA_BITS +: DATA_BITS];
                     state[c] <= S_RELAY;
                  end
               end
               S_WRITE_WAIT: begin
                  if (mem_write_ready[c]) begin
                     consumer_resp_ready[lane[c]] <= 1'b1;
                     state[c] <= S_RELAY;
                  end
               end
               default: begin
                  // A held valid keeps the lane parked here so it is not serviced twice.
                  if (!consumer_valid[lane[c]])
                     state[c] <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_controller.sv
`default_nettype none
// tb_data_mem_controller: directed scenarios against a latency-programmable memory
// responder, plus a single-channel instance for round-robin fairness.
module tb_data_mem_controller;

   localparam int NC  = 5;
   localparam int NCH = 2;
   localparam int AB  = 8;
   localparam int DB  = 16;

   logic            clk;
   logic            reset;
   logic [NC-1:0]   consumer_valid;
   logic [NC-1:0]   consumer_we;
   logic [NC*AB-1:0] consumer_addr;
   logic [NC*DB-1:0] consumer_data;
   logic [NC-1:0]   resp_ready;
   logic [NC*DB-1:0] resp_data;
   logic [NCH-1:0]  rv, wv, rrdy, wrdy;
   logic [NCH*AB-1:0] ra, wa;
   logic [NCH*DB-1:0] rd, wd;

   // single-channel instance
   logic [NC-1:0]    valid1;
   logic [NC-1:0]    resp_ready1;
   logic [NC*DB-1:0] resp_data1;
   logic [0:0]       rv1, wv1;
   logic [AB-1:0]    ra1, wa1;
   logic [DB-1:0]    wd1;

   int   lat;
   logic stray;
   int   cnt [NCH];
   logic [DB-1:0] mem [256];

   int vectors;
   int miscompares;

   data_mem_controller #(.NUM_CONSUMERS(NC), .NUM_CHANNELS(NCH), .ADDR_BITS(AB), .DATA_BITS(DB)) u_dut (
      .clk(clk), .reset(reset),
      .consumer_valid(consumer_valid), .consumer_addr(consumer_addr),
      .consumer_data(consumer_data), .consumer_we(consumer_we),
      .consumer_resp_ready(resp_ready), .consumer_resp_data(resp_data),
      .mem_read_valid(rv), .mem_read_addr(ra), .mem_read_ready(rrdy), .mem_read_data(rd),
      .mem_write_valid(wv), .mem_write_addr(wa), .mem_write_data(wd), .mem_write_ready(wrdy)
   );

   data_mem_controller #(.NUM_CONSUMERS(NC), .NUM_CHANNELS(1), .ADDR_BITS(AB), .DATA_BITS(DB)) u_dut1 (
      .clk(clk), .reset(reset),
      .consumer_valid(valid1), .consumer_addr(consumer_addr),
      .consumer_data(consumer_data), .consumer_we(consumer_we),
      .consumer_resp_ready(resp_ready1), .consumer_resp_data(resp_data1),
      .mem_read_valid(rv1), .mem_read_addr(ra1), .mem_read_ready(rv1), .mem_read_data(16'h0),
      .mem_write_valid(wv1), .mem_write_addr(wa1), .mem_write_data(wd1), .mem_write_ready(wv1)
   );

   always #5 clk = ~clk;

   // Memory responder: ready in the lat-th cycle that a channel's request is visible.
   always_comb begin
      for (int c = 0; c < NCH; c++) begin
         rrdy[c] = stray | (rv[c] && cnt[c] == lat - 1);
         wrdy[c] = stray | (wv[c] && cnt[c] == lat - 1);
         rd[c*DB +: DB] = mem[ra[c*AB +: AB]];
      end
   end

   always @(posedge clk) begin
      for (int c = 0; c < NCH; c++) begin
         if (!(rv[c] | wv[c]) || rrdy[c] || wrdy[c]) cnt[c] <= 0;
         else cnt[c] <= cnt[c] + 1;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int l, input logic [AB-1:0] a, input logic [DB-1:0] d, input logic we);
      consumer_addr[l*AB +: AB] = a;
      consumer_data[l*DB +: DB] = d;
      consumer_we[l]            = we;
      consumer_valid[l]         = 1'b1;
   endtask

   task automatic test_reset();
      vectors++;
      if (resp_ready !== '0 || resp_data !== '0) begin
         $display("FAIL reset_resp: ready=%b data=%h want 0", resp_ready, resp_data); miscompares++;
      end
      vectors++;
      if (rv !== '0 || wv !== '0 || ra !== '0 || wa !== '0 || wd !== '0) begin
         $display("FAIL reset_mem: rv=%b wv=%b ra=%h wa=%h wd=%h want 0", rv, wv, ra, wa, wd); miscompares++;
      end
   endtask

   task automatic test_read();
      lat = 2;
      set_req(0, 8'h12, 16'h0, 1'b0);
      step();
      vectors++;
      if (rv !== 2'b01 || ra[AB-1:0] !== 8'h12 || wv !== 2'b00) begin
         $display("FAIL read_req: rv=%b addr=%h wv=%b want 01/12/00", rv, ra[AB-1:0], wv); miscompares++;
      end
      step();
      vectors++;
      if (resp_ready !== '0 || rv !== 2'b01) begin
         $display("FAIL read_wait: resp=%b rv=%b want 00000/01", resp_ready, rv); miscompares++;
      end
      step();
      vectors++;
      if (resp_ready !== 5'b00001 || resp_data[DB-1:0] !== 16'hBEEF) begin
         $display("FAIL read_resp: resp=%b data=%h want 00001/beef", resp_ready, resp_data[DB-1:0]); miscompares++;
      end
      vectors++;
      if (rv !== 2'b00) begin
         $display("FAIL read_drop: rv=%b want 00", rv); miscompares++;
      end
      consumer_valid = '0;
      step();
      vectors++;
      if (resp_ready !== '0 || resp_data[DB-1:0] !== 16'hBEEF) begin
         $display("FAIL read_hold: resp=%b data=%h want 0/beef", resp_ready, resp_data[DB-1:0]); miscompares++;
      end
   endtask

   task automatic test_min_latency();
      lat = 1;
      set_req(1, 8'h13, 16'h0, 1'b0);
      step();
      vectors++;
      if (rv !== 2'b01 || rrdy !== 2'b01) begin
         $display("FAIL minlat_req: rv=%b rdy=%b want 01/01", rv, rrdy); miscompares++;
      end
      step();
      vectors++;
      if (resp_ready !== 5'b00010 || resp_data[DB +: DB] !== 16'h5A5A) begin
         $display("FAIL minlat_resp: resp=%b data=%h want 00010/5a5a", resp_ready, resp_data[DB +: DB]); miscompares++;
      end
      consumer_valid = '0;
      step();
   endtask

   task automatic test_write();
      int pulses = 0;
      lat = 3;
      set_req(4, 8'h40, 16'h1234, 1'b1);
      for (int i = 1; i <= 3; i++) begin
         step();
         vectors++;
         if (wv !== 2'b01 || wa[AB-1:0] !== 8'h40 || wd[DB-1:0] !== 16'h1234 || rv !== 2'b00 || resp_ready !== '0) begin
            $display("FAIL write_hold c%0d: wv=%b wa=%h wd=%h rv=%b resp=%b want 01/40/1234/00/0",
                     i, wv, wa[AB-1:0], wd[DB-1:0], rv, resp_ready);
            miscompares++;
         end
      end
      step();
      vectors++;
      if (resp_ready !== 5'b10000 || wv !== 2'b00) begin
         $display("FAIL write_resp: resp=%b wv=%b want 10000/00", resp_ready, wv); miscompares++;
      end
      vectors++;
      if (resp_data[4*DB +: DB] !== 16'h0000) begin
         $display("FAIL write_data_unchanged: got %h want 0000", resp_data[4*DB +: DB]); miscompares++;
      end
      consumer_valid = '0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (resp_ready[4]) pulses++;
      end
      vectors++;
      if (pulses != 0) begin
         $display("FAIL write_single_pulse: extra pulses %0d want 0", pulses); miscompares++;
      end
   endtask

   task automatic test_contention();
      int np [4];
      int pc [4];
      int exp_c [4] = '{3, 3, 7, 7};
      lat = 2;
      for (int l = 0; l < 4; l++) begin
         np[l] = 0; pc[l] = -1;
         set_req(l, 8'h20 + 8'(l), 16'h0, 1'b0);
      end
      for (int i = 1; i <= 12; i++) begin
         step();
         vectors++;
         if ($countones({rv, wv}) > 2) begin
            $display("FAIL contention_chan c%0d: rv=%b wv=%b more than 2", i, rv, wv); miscompares++;
         end
         for (int l = 0; l < 4; l++) begin
            if (resp_ready[l]) begin
               np[l]++; pc[l] = i;
               consumer_valid[l] = 1'b0;
               vectors++;
               if (resp_data[l*DB +: DB] !== 16'hA000 + 16'(l)) begin
                  $display("FAIL contention_data lane%0d: got %h want %h", l, resp_data[l*DB +: DB], 16'hA000 + 16'(l));
                  miscompares++;
               end
            end
         end
      end
      for (int l = 0; l < 4; l++) begin
         vectors++;
         if (np[l] != 1 || pc[l] != exp_c[l]) begin
            $display("FAIL contention_pulse lane%0d: count=%0d cycle=%0d want 1/%0d", l, np[l], pc[l], exp_c[l]);
            miscompares++;
         end
      end
   endtask

   task automatic test_held_valid();
      lat = 2;
      set_req(2, 8'h22, 16'h0, 1'b0);
      step(); step(); step();
      vectors++;
      if (resp_ready !== 5'b00100 || resp_data[2*DB +: DB] !== 16'hA002) begin
         $display("FAIL held_first: resp=%b data=%h want 00100/a002", resp_ready, resp_data[2*DB +: DB]); miscompares++;
      end
      for (int i = 1; i <= 5; i++) begin
         step();
         vectors++;
         if (rv !== 2'b00 || resp_ready !== '0) begin
            $display("FAIL held_no_reissue c%0d: rv=%b resp=%b want 00/0", i, rv, resp_ready); miscompares++;
         end
      end
      consumer_valid[2] = 1'b0;
      step();
      consumer_valid[2] = 1'b1;
      step();
      vectors++;
      if (rv !== 2'b01 || ra[AB-1:0] !== 8'h22) begin
         $display("FAIL held_rerequest: rv=%b addr=%h want 01/22", rv, ra[AB-1:0]); miscompares++;
      end
      step(); step();
      vectors++;
      if (resp_ready !== 5'b00100) begin
         $display("FAIL held_second_pulse: resp=%b want 00100", resp_ready); miscompares++;
      end
      consumer_valid = '0;
      step();
   endtask

   task automatic test_stray_ready();
      stray = 1'b1;
      step();
      stray = 1'b0;
      step();
      vectors++;
      if (resp_ready !== '0 || rv !== '0 || wv !== '0) begin
         $display("FAIL stray_ready: resp=%b rv=%b wv=%b want 0", resp_ready, rv, wv); miscompares++;
      end
   endtask

   task automatic test_fairness();
      int grants [4];
      int n = 0;
      logic [NC-1:0] pend = '0;
      valid1 = 5'b00011;
      for (int i = 0; i < 40 && n < 4; i++) begin
         step();
         valid1 = valid1 | pend;
         pend   = '0;
         vectors++;
         if ($countones(resp_ready1) > 1 || resp_ready1[NC-1:2] !== '0) begin
            $display("FAIL fair_pulse c%0d: resp=%b", i, resp_ready1); miscompares++;
         end
         for (int l = 0; l < 2; l++) begin
            if (resp_ready1[l] && n < 4) begin
               grants[n] = l; n++;
               valid1[l] = 1'b0;
               pend[l]   = 1'b1;
            end
         end
      end
      valid1 = '0;
      vectors++;
      if (n != 4) begin
         $display("FAIL fair_timeout: got %0d grants want 4", n); miscompares++;
      end else begin
         for (int g = 0; g < 4; g++) begin
            vectors++;
            if (grants[g] != g % 2) begin
               $display("FAIL fair_order grant%0d: lane %0d want %0d", g, grants[g], g % 2); miscompares++;
            end
         end
      end
      step(); step();
   endtask

   task automatic test_reset_mid();
      int pulses = 0;
      lat = 5;
      set_req(3, 8'h23, 16'h0, 1'b0);
      step();
      vectors++;
      if (rv !== 2'b01) begin
         $display("FAIL rstmid_pre: rv=%b want 01", rv); miscompares++;
      end
      #2 reset = 1'b0;
      #1;
      vectors++;
      if (rv !== '0 || wv !== '0 || ra !== '0 || resp_ready !== '0 || resp_data !== '0) begin
         $display("FAIL rstmid_outputs: rv=%b wv=%b ra=%h resp=%b data=%h want 0", rv, wv, ra, resp_ready, resp_data);
         miscompares++;
      end
      consumer_valid = '0;
      step();
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         if (resp_ready !== '0 || rv !== '0) pulses++;
      end
      vectors++;
      if (pulses != 0) begin
         $display("FAIL rstmid_stale: %0d cycles with activity want 0", pulses); miscompares++;
      end
      lat = 2;
      set_req(3, 8'h23, 16'h0, 1'b0);
      step(); step(); step();
      vectors++;
      if (resp_ready !== 5'b01000 || resp_data[3*DB +: DB] !== 16'hA003) begin
         $display("FAIL rstmid_new: resp=%b data=%h want 01000/a003", resp_ready, resp_data[3*DB +: DB]);
         miscompares++;
      end
      consumer_valid = '0;
      step();
   endtask

   initial begin
      clk = 1'b0; reset = 1'b0;
      consumer_valid = '0; consumer_we = '0; consumer_addr = '0; consumer_data = '0;
      valid1 = '0; lat = 1; stray = 1'b0;
      vectors = 0; miscompares = 0;
      for (int i = 0; i < 256; i++) mem[i] = 16'h0;
      mem[8'h12] = 16'hBEEF;
      mem[8'h13] = 16'h5A5A;
      for (int i = 0; i < 4; i++) mem[8'h20 + i] = 16'hA000 + 16'(i);
      step(); step();
      test_reset();
      reset = 1'b1;
      step();
      test_reset();
      test_read();
      test_min_latency();
      test_write();
      test_contention();
      test_held_valid();
      test_stray_ready();
      test_fairness();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
